// File: rtl/wave_capture_if.sv
// wave_capture_if
//   Groups the sample input stream, the display-idle hint and the display
//   RAM write port of wave_capture into one bundle.
//
//   Signals
//     new_sample         one-cycle strobe, sample valid in that cycle
//     sample             signed 16-bit audio sample
//     wave_display_idle  display is outside its wave region (safe to swap)
//     write_address      {~read_index, offset[7:0]}
//     write_sample       offset-binary top byte of the sample
//     write_enable       single-cycle RAM write strobe
//     read_index         RAM half currently shown by the display
//
//   Modports
//     master  drives the sample stream and idle hint, observes the RAM port
//     slave   the capture block itself
interface wave_capture_if;
  logic              new_sample;
  logic signed [15:0] sample;
  logic              wave_display_idle;
  logic [8:0]        write_address;
  logic [7:0]        write_sample;
  logic              write_enable;
  logic              read_index;

  modport master (
    output new_sample, sample, wave_display_idle,
    input  write_address, write_sample, write_enable, read_index
  );

  modport slave (
    input  new_sample, sample, wave_display_idle,
    output write_address, write_sample, write_enable, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// wave_capture
//   Triggered oscilloscope capture into a double-buffered (2 x 256 entry)
//   display RAM. A capture starts on a positive zero crossing of the signed
//   sample stream, stores 256 consecutive samples into the half the display
//   is not reading, then waits for the display to go idle before swapping
//   halves and re-arming.
//
//   Ports
//     clk    system clock, all registers on its rising edge
//     reset  asynchronous, active-high
//     bus    wave_capture_if.slave (sample stream in, RAM write port out)
module wave_capture (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  bus
);

  localparam int DATA_W = 16;
  localparam int OFFS_W = 8;
  localparam int ADDR_W = OFFS_W + 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t                    state;
  logic [OFFS_W-1:0]         offset;
  logic signed [DATA_W-1:0]  prev_sample;
  logic                      read_index_q;

  logic                      wr_vld_p1;
  logic [ADDR_W-1:0]         wr_addr_p1;
  logic [7:0]                wr_data_p1;

  logic                      crossing;
  logic                      accept;
  logic [OFFS_W-1:0]         wr_offset;

  // Offset-binary byte from the sample's top byte: flipping the sign bit
  // maps -32768..32767 onto 0x00..0xFF so the display can treat it as an
  // unsigned vertical position.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] msb);
    return {~msb[7], msb[6:0]};
  endfunction

  // prev_sample is the value before this cycle's update, so a crossing
  // compares the previous accepted sample with the one arriving now.
  assign crossing = bus.new_sample && (prev_sample < 16'sd0) && !bus.sample[DATA_W-1];

  always_comb begin
    accept    = 1'b0;
    wr_offset = offset;
    case (state)
      ARMED: begin
        accept    = crossing;
        wr_offset = '0;
      end
      ACTIVE: begin
        accept    = bus.new_sample;
      end
      default: begin
        accept    = 1'b0;
      end
    endcase
  end

  // ---- p0 -> p1: accept sample, register RAM write and advance FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARMED;
      offset       <= '0;
      prev_sample  <= '0;
      read_index_q <= 1'b0;
      wr_vld_p1    <= 1'b0;
      wr_addr_p1   <= '0;
      wr_data_p1   <= '0;
    end else begin
      wr_vld_p1 <= accept;

      if (bus.new_sample) begin
        prev_sample <= bus.sample;
      end

      // Address and data only move on an accepted sample and otherwise hold.
      if (accept) begin
        wr_addr_p1 <= {~read_index_q, wr_offset};
        wr_data_p1 <= to_offset_binary(bus.sample[DATA_W-1:DATA_W-8]);
        offset     <= wr_offset + 8'd1;
      end

      case (state)
        ARMED: begin
          if (crossing) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // offset wraps 255 -> 0 through the increment above.
          if (bus.new_sample && (offset == 8'hFF)) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.wave_display_idle) begin
            read_index_q <= ~read_index_q;
            state        <= ARMED;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

  assign bus.write_enable  = wr_vld_p1;
  assign bus.write_address = wr_addr_p1;
  assign bus.write_sample  = wr_data_p1;
  assign bus.read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture
//   Self-checking bench for wave_capture: a table of directed vectors,
//   hand-written multi-cycle sequences (full frame, swap, async reset,
//   swap-with-sample) and a randomized phase, all compared against a
//   behavioural model of the capture rules.
module tb_wave_capture;

  logic clk;
  logic reset;

  wave_capture_if vif ();

  wave_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: m_cnt = -1 while waiting for a trigger, 0..255 =
  // samples stored so far in the current frame, 256 = frame full.
  int                 m_cnt;
  bit                 m_ri;
  logic signed [15:0] m_prev;
  bit                 m_we;
  logic [8:0]         m_addr;
  logic [7:0]         m_data;

  function automatic void m_reset();
    m_cnt  = -1;
    m_ri   = 1'b0;
    m_prev = 16'sd0;
    m_we   = 1'b0;
    m_addr = 9'd0;
    m_data = 8'd0;
  endfunction

  function automatic void m_step(bit ns, logic signed [15:0] s, bit idle);
    int off;
    off  = -1;
    m_we = 1'b0;
    if (m_cnt == 256) begin
      if (idle) begin
        m_ri  = ~m_ri;
        m_cnt = -1;
      end
    end else if (ns) begin
      if (m_cnt < 0) begin
        if (m_prev < 0 && s >= 0) off = 0;
      end else begin
        off = m_cnt;
      end
    end
    if (off >= 0) begin
      m_we   = 1'b1;
      m_addr = 9'((m_ri ? 0 : 256) + off);
      m_data = 8'((int'(s) + 32768) >> 8);
      m_cnt  = off + 1;
    end
    if (ns) m_prev = s;
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic chk_model();
    chk("model write_enable",  int'(vif.write_enable),  int'(m_we));
    chk("model write_address", int'(vif.write_address), int'(m_addr));
    chk("model write_sample",  int'(vif.write_sample),  int'(m_data));
    chk("model read_index",    int'(vif.read_index),    int'(m_ri));
  endtask

  // Apply one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input bit ns, input logic signed [15:0] s, input bit idle);
    vif.new_sample        = ns;
    vif.sample            = s;
    vif.wave_display_idle = idle;
    @(posedge clk);
    m_step(ns, s, idle);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit                 ns;
    logic signed [15:0] s;
    bit                 idle;
    bit                 we;
    logic [8:0]         addr;
    logic [7:0]         data;
    bit                 ri;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, -16'sd100,   1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    tbl[1] = '{1'b1,  16'sd50,    1'b0, 1'b1, 9'h100, 8'h80, 1'b0};
    tbl[2] = '{1'b1,  16'sd32767, 1'b0, 1'b1, 9'h101, 8'hFF, 1'b0};
    tbl[3] = '{1'b1, -16'sd1,     1'b0, 1'b1, 9'h102, 8'h7F, 1'b0};
    tbl[4] = '{1'b0,  16'sd0,     1'b1, 1'b0, 9'h102, 8'h7F, 1'b0};
    tbl[5] = '{1'b1, -16'sd32768, 1'b0, 1'b1, 9'h103, 8'h00, 1'b0};

    reset                 = 1'b1;
    vif.new_sample        = 1'b0;
    vif.sample            = 16'sd0;
    vif.wave_display_idle = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset write_enable",  int'(vif.write_enable),  0);
    chk("reset write_address", int'(vif.write_address), 0);
    chk("reset write_sample",  int'(vif.write_sample),  0);
    chk("reset read_index",    int'(vif.read_index),    0);
    reset = 1'b0;

    // Directed table: trigger on -100 -> 50, then a few extreme samples.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].ns, tbl[i].s, tbl[i].idle);
      chk($sformatf("tbl[%0d] we", i),   int'(vif.write_enable),  int'(tbl[i].we));
      chk($sformatf("tbl[%0d] addr", i), int'(vif.write_address), int'(tbl[i].addr));
      chk($sformatf("tbl[%0d] data", i), int'(vif.write_sample),  int'(tbl[i].data));
      chk($sformatf("tbl[%0d] ri", i),   int'(vif.read_index),    int'(tbl[i].ri));
    end

    // Finish the frame back-to-back: offsets 4..255 into the upper half.
    for (int i = 4; i < 256; i++) begin
      step(1'b1, 16'($urandom), 1'b0);
      chk("frame1 we",   int'(vif.write_enable),  1);
      chk("frame1 addr", int'(vif.write_address), 9'h100 + i);
    end
    step(1'b1, -16'sd200, 1'b0);
    chk("257th no write", int'(vif.write_enable),  0);
    chk("257th addr hold", int'(vif.write_address), 9'h1FF);
    step(1'b1, 16'sd300, 1'b0);
    chk("wait crossing ignored", int'(vif.write_enable), 0);

    // Swap halves, then capture into the lower half.
    step(1'b0, 16'sd0, 1'b1);
    chk("swap read_index", int'(vif.read_index), 1);
    step(1'b1, -16'sd5, 1'b0);
    chk("armed no write", int'(vif.write_enable), 0);
    step(1'b1, 16'sd7, 1'b0);
    chk("frame2 trigger we",   int'(vif.write_enable),  1);
    chk("frame2 trigger addr", int'(vif.write_address), 9'h000);
    for (int i = 1; i < 100; i++) begin
      step(1'b1, 16'($urandom), 1'b0);
      chk("frame2 addr", int'(vif.write_address), i);
    end

    // Asynchronous reset between edges, mid-capture.
    vif.new_sample = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async rst write_enable",  int'(vif.write_enable),  0);
    chk("async rst write_address", int'(vif.write_address), 0);
    chk("async rst write_sample",  int'(vif.write_sample),  0);
    chk("async rst read_index",    int'(vif.read_index),    0);
    m_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Only non-negative samples while armed: no trigger, no swap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'sh1234, 1'($urandom_range(0, 1)));
      chk("nonneg no write", int'(vif.write_enable), 0);
      chk("nonneg ri",       int'(vif.read_index),   0);
    end
    step(1'b1, -16'sd9, 1'b0);
    step(1'b1, 16'sd9, 1'b0);
    chk("restart we",   int'(vif.write_enable),  1);
    chk("restart addr", int'(vif.write_address), 9'h100);
    for (int i = 1; i < 256; i++) step(1'b1, 16'($urandom), 1'b0);
    chk("frame3 last addr", int'(vif.write_address), 9'h1FF);

    // Swap with a simultaneous negative sample, then an immediate crossing.
    step(1'b1, -16'sd1, 1'b1);
    chk("swap+sample no write", int'(vif.write_enable), 0);
    chk("swap+sample ri",       int'(vif.read_index),   1);
    step(1'b1, 16'sd1, 1'b0);
    chk("post-swap trigger we",   int'(vif.write_enable),  1);
    chk("post-swap trigger addr", int'(vif.write_address), 9'h000);
    chk("post-swap trigger data", int'(vif.write_sample),  8'h80);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(bit'($urandom_range(0, 9) < 7), 16'($urandom), bit'($urandom_range(0, 9) < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 The block SHALL have no parameters; sample width is 16 bits and the capture depth is 256 entries per half, both fixed.
REQ-002 clk  input  1  The single system clock; every register in the block SHALL be clocked on its rising edge.
REQ-003 reset  input  1  Reset SHALL be asynchronous and active-high, and SHALL act immediately regardless of clk.
REQ-004 new_sample  input  1  One-cycle strobe; sample is valid in that cycle.
REQ-005 sample  input  16  Signed two's-complement audio sample.
REQ-006 wave_display_idle  input  1  High while the display is outside its active wave region; a safe moment to swap halves.
REQ-007 write_address  output  9  Display RAM write address: {~read_index, offset[7:0]}.
REQ-008 write_sample  output  8  Offset-binary sample byte: {~sample[15], sample[14:8]}.
REQ-009 write_enable  output  1  Single-cycle RAM write strobe.
REQ-010 read_index  output  1  Selects the RAM half the display reads; the capture side always writes the other half.

Function
REQ-011 The state machine SHALL have exactly three states: ARMED, ACTIVE and WAIT.
REQ-012 The block SHALL hold prev_sample[15:0], updated with sample on every new_sample in every state.
REQ-013 A positive zero crossing SHALL be defined as new_sample=1 with prev_sample[15]=1 and sample[15]=0; the comparison SHALL use prev_sample before that cycle's update.
REQ-014 ARMED: on a crossing, the FSM SHALL go to ACTIVE, the crossing sample SHALL be written at offset 0, and offset SHALL become 1.
REQ-015 ARMED: new_sample without a crossing SHALL produce no write, and the FSM SHALL remain in ARMED.
REQ-016 ACTIVE: each new_sample SHALL be written at the current offset, and offset SHALL then increment by 1.
REQ-017 ACTIVE: the write at offset 255 SHALL be the last; the FSM SHALL go to WAIT, and offset SHALL wrap to 0 (8-bit wrap, no overflow flag).
REQ-018 WAIT: new_sample SHALL be ignored apart from the prev_sample update (REQ-012).
REQ-019 WAIT: wave_display_idle=1 SHALL toggle read_index and move the FSM to ARMED on the same edge.
REQ-020 wave_display_idle SHALL be ignored in ARMED and ACTIVE.
REQ-021 The write outputs SHALL be registered with 1-cycle latency: write_enable, write_address and write_sample SHALL be valid in the cycle after the accepting new_sample.
REQ-022 write_enable SHALL be high for exactly one cycle per accepted sample.
REQ-023 write_address SHALL use the read_index value current at the time the sample is accepted.
REQ-024 write_address and write_sample SHALL hold their last values while write_enable=0.
REQ-025 If new_sample and wave_display_idle are both high in WAIT: the swap SHALL occur, no write SHALL occur, and prev_sample SHALL update; that sample SHALL therefore count as prev for crossing detection in ARMED.
REQ-026 Back-to-back new_sample (every cycle) SHALL be supported with no lost samples in ACTIVE.
REQ-027 There SHALL be no timeout; the FSM SHALL remain in ARMED indefinitely until a crossing.

Reset
REQ-028 On reset the block SHALL set: state=ARMED, offset=0, prev_sample=16'h0000, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-029 Reset asserted mid-ACTIVE SHALL abandon the partial capture, and read_index SHALL return to 0.
REQ-030 Because prev_sample resets to 16'h0000 (non-negative), the first sample after reset SHALL never be treated as a crossing.

Verification
REQ-031 Bench: after reset, samples -100 then 50 -> the 50 is accepted; the next cycle shows write_enable=1, write_address=9'h100, write_sample=8'h80.
REQ-032 Bench: 256 samples accepted from a crossing, one per cycle -> writes to addresses 9'h100..9'h1FF; state=WAIT after the 256th; the 257th sample produces no write.
REQ-033 Bench: in WAIT, raise wave_display_idle -> read_index goes 0->1 on the next edge; the next capture writes addresses 9'h000..9'h0FF.
REQ-034 Bench: only non-negative samples (e.g. 16'h1234 repeated) in ARMED -> write_enable stays 0 and read_index never changes.
REQ-035 Bench: assert reset asynchronously (between clock edges) after 100 writes in ACTIVE -> outputs become 0 immediately, with no clock edge needed; after release, a crossing restarts the capture at address 9'h100.
REQ-036 Bench: in WAIT, new_sample=-1 together with wave_display_idle=1, then sample=+1 next -> read_index toggles, then an immediate crossing writes offset 0 of the new write half.
